// File: rtl/mdu_seq_ctl.sv
// rtl/mdu_seq_ctl.sv - sequencer for the iterative shift-add multiply/divide datapath
//
// Build option: MDU_MADDU_EN
//   defined   : funct 1 (maddu) is sequenced and accumulates into {HI,LO} at commit.
//   undefined : only multu (funct 25) is sequenced; funct 1 is ignored and hilo_acc is 0.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   issue_valid     EX holds an R-type instruction
//   issue_funct     funct field of that instruction
//   mf_req          EX holds mfhi/mflo
//   flush           squash the in-flight multiply
//   stall           freeze IF/ID/EX (combinational)
//   busy            sequencer is not idle
//   mul_load        datapath latches operands, clears partial product
//   mul_step        datapath performs one shift-add iteration
//   mul_op          000000 idle, 011001 multu, 000001 maddu, 111111 commit
//   hilo_we         write product into HI/LO at the next edge
//   hilo_acc        with hilo_we, accumulate instead of overwrite
//   done            one-cycle pulse coincident with hilo_we
//   step_cnt        current iteration index (debug)

module mdu_seq_ctl #(
    parameter int STEPS = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic [5:0]       issue_funct,
    input  logic             mf_req,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             mul_load,
    output logic             mul_step,
    output logic [5:0]       mul_op,
    output logic             hilo_we,
    output logic             hilo_acc,
    output logic             done,
    output logic [CNT_W-1:0] step_cnt
);

    localparam logic [5:0] FUNCT_MULTU = 6'd25;
    localparam logic [5:0] FUNCT_MADDU = 6'd1;
    localparam logic [5:0] OP_IDLE     = 6'b000000;
    localparam logic [5:0] OP_MULTU    = 6'b011001;
    localparam logic [5:0] OP_MADDU    = 6'b000001;
    localparam logic [5:0] OP_COMMIT   = 6'b111111;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_RUN    = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             op_maddu;
    logic             op_maddu_nxt;

    logic             issue_maddu;
    logic             issue_mul;
    logic             accept;

    // Instruction decode: only funct codes the build supports count as a mul.
`ifdef MDU_MADDU_EN
    assign issue_maddu = (issue_funct == FUNCT_MADDU);
`else
    assign issue_maddu = 1'b0;
`endif
    assign issue_mul = (issue_funct == FUNCT_MULTU) | issue_maddu;

    // In IDLE a flush wins over a simultaneous issue.
    assign accept = (state == S_IDLE) & issue_valid & issue_mul & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= CNT_ZERO;
            op_maddu <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            op_maddu <= op_maddu_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        op_maddu_nxt = op_maddu;
        case (state)
            S_IDLE: begin
                cnt_nxt = CNT_ZERO;
                if (accept) begin
                    state_nxt    = S_LOAD;
                    op_maddu_nxt = issue_maddu;
                end
            end
            S_LOAD: begin
                cnt_nxt   = CNT_ZERO;
                state_nxt = flush ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (flush) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = CNT_ZERO;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_COMMIT;
                    cnt_nxt   = CNT_ZERO;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            S_COMMIT: begin
                // A commit is already architecturally visible; flush cannot cancel it.
                state_nxt = S_IDLE;
                cnt_nxt   = CNT_ZERO;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    always_comb begin
        busy     = (state != S_IDLE);
        mul_load = 1'b0;
        mul_step = 1'b0;
        mul_op   = OP_IDLE;
        hilo_we  = 1'b0;
        hilo_acc = 1'b0;
        done     = 1'b0;
        case (state)
            S_LOAD: begin
                mul_load = 1'b1;
                mul_op   = op_maddu ? OP_MADDU : OP_MULTU;
            end
            S_RUN: begin
                mul_step = 1'b1;
                mul_op   = op_maddu ? OP_MADDU : OP_MULTU;
            end
            S_COMMIT: begin
                hilo_we = 1'b1;
                done    = 1'b1;
                mul_op  = OP_COMMIT;
`ifdef MDU_MADDU_EN
                hilo_acc = op_maddu;
`else
                hilo_acc = 1'b0;
`endif
            end
            default: begin
                mul_op = OP_IDLE;
            end
        endcase
    end

    // A held request is dropped in a flush cycle, so it must not keep EX frozen.
    assign stall    = busy & ((issue_valid & issue_mul) | mf_req) & ~flush;
    assign step_cnt = cnt;

endmodule

// File: tb/tb_mdu_seq_ctl.sv
// tb/tb_mdu_seq_ctl.sv - directed self-checking bench for mdu_seq_ctl
module tb_mdu_seq_ctl;

    localparam int STEPS = 32;
    localparam int CNT_W = 6;

    logic             clk;
    logic             rst_n;
    logic             issue_valid;
    logic [5:0]       issue_funct;
    logic             mf_req;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             mul_load;
    logic             mul_step;
    logic [5:0]       mul_op;
    logic             hilo_we;
    logic             hilo_acc;
    logic             done;
    logic [CNT_W-1:0] step_cnt;

    int n_checks;
    int n_fails;

    mdu_seq_ctl #(.STEPS(STEPS), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_funct (issue_funct),
        .mf_req      (mf_req),
        .flush       (flush),
        .stall       (stall),
        .busy        (busy),
        .mul_load    (mul_load),
        .mul_step    (mul_step),
        .mul_op      (mul_op),
        .hilo_we     (hilo_we),
        .hilo_acc    (hilo_acc),
        .done        (done),
        .step_cnt    (step_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Present an issue for one edge; returns in the LOAD cycle.
    task automatic issue(input logic [5:0] f);
        issue_valid = 1'b1;
        issue_funct = f;
        tick();
        issue_valid = 1'b0;
        issue_funct = 6'd0;
    endtask

    // From the LOAD cycle, walk 34 busy cycles and check the whole sequence.
    task automatic run_full(input string tag, input logic [5:0] op, input logic acc);
        int loads, steps, cnt_err, op_err, we_early;
        loads = 0; steps = 0; cnt_err = 0; op_err = 0; we_early = 0;
        for (int k = 0; k < STEPS + 2; k++) begin
            loads += int'(mul_load);
            steps += int'(mul_step);
            if (k >= 1 && k <= STEPS && step_cnt !== CNT_W'(k - 1)) cnt_err++;
            if (k <= STEPS && mul_op !== op) op_err++;
            if (k <= STEPS && (hilo_we | done)) we_early++;
            if (k == STEPS + 1) begin
                chk({tag, "_hilo_we"}, 32'(hilo_we), 32'd1);
                chk({tag, "_done"}, 32'(done), 32'd1);
                chk({tag, "_hilo_acc"}, 32'(hilo_acc), 32'(acc));
                chk({tag, "_op_commit"}, 32'(mul_op), 32'h3f);
            end
            tick();
        end
        chk({tag, "_load_cycles"}, 32'(loads), 32'd1);
        chk({tag, "_step_cycles"}, 32'(steps), 32'd32);
        chk({tag, "_cnt_errs"}, 32'(cnt_err), 32'd0);
        chk({tag, "_op_errs"}, 32'(op_err), 32'd0);
        chk({tag, "_we_early"}, 32'(we_early), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_op"}, 32'(mul_op), 32'd0);
    endtask

    initial begin
        int bad, guard;
        n_checks = 0;
        n_fails  = 0;
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        issue_funct = 6'd0;
        mf_req      = 1'b0;
        flush       = 1'b0;

        // Reset state
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_outs", 32'({stall, mul_load, mul_step, hilo_we, hilo_acc, done}), 32'd0);
        chk("rst_op", 32'(mul_op), 32'd0);
        chk("rst_cnt", 32'(step_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic multu
        issue_valid = 1'b1;
        issue_funct = 6'd25;
        #1;
        chk("idle_no_stall", 32'(stall), 32'd0);
        issue(6'd25);
        chk("multu_load", 32'(mul_load), 32'd1);
        chk("multu_load_cnt", 32'(step_cnt), 32'd0);
        run_full("multu", 6'b011001, 1'b0);

        // maddu
`ifdef MDU_MADDU_EN
        issue(6'd1);
        run_full("maddu", 6'b000001, 1'b1);
`else
        issue(6'd1);
        chk("maddu_off_busy", 32'(busy), 32'd0);
        chk("maddu_off_load", 32'(mul_load), 32'd0);
`endif

        // Non-mul funct ignored
        issue(6'd32);
        chk("nonmul_busy", 32'(busy), 32'd0);

        // mf_req during RUN at step_cnt 10
        issue(6'd25);
        for (int i = 0; i < 11; i++) tick();
        chk("mf_cnt10", 32'(step_cnt), 32'd10);
        mf_req = 1'b1;
        #1;
        chk("mf_stall", 32'(stall), 32'd1);
        bad = 0; guard = 0;
        while (busy && guard < 40) begin
            if (!stall) bad++;
            tick();
            guard++;
        end
        chk("mf_stall_held", 32'(bad), 32'd0);
        chk("mf_guard", 32'(guard < 40), 32'd1);
        chk("mf_idle_stall", 32'(stall), 32'd0);
        mf_req = 1'b0;
        tick();

        // Second multu at step_cnt 5
        issue(6'd25);
        for (int i = 0; i < 6; i++) tick();
        chk("mul2_cnt5", 32'(step_cnt), 32'd5);
        issue_valid = 1'b1;
        issue_funct = 6'd25;
        #1;
        chk("mul2_stall", 32'(stall), 32'd1);
        bad = 0; guard = 0;
        while (busy && guard < 40) begin
            if (!stall) bad++;
            tick();
            guard++;
        end
        chk("mul2_stall_held", 32'(bad), 32'd0);
        chk("mul2_guard", 32'(guard < 40), 32'd1);
        chk("mul2_idle_stall", 32'(stall), 32'd0);
        tick();
        issue_valid = 1'b0;
        issue_funct = 6'd0;
        #1;
        chk("mul2_reload", 32'(mul_load), 32'd1);
        run_full("mul2", 6'b011001, 1'b0);

        // Flush at step_cnt 20
        issue(6'd25);
        for (int i = 0; i < 21; i++) tick();
        chk("fl_cnt20", 32'(step_cnt), 32'd20);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("fl_busy", 32'(busy), 32'd0);
        chk("fl_cnt", 32'(step_cnt), 32'd0);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (hilo_we | done) bad++;
            tick();
        end
        chk("fl_no_commit", 32'(bad), 32'd0);

        // Flush during COMMIT
        issue(6'd25);
        for (int i = 0; i < STEPS + 1; i++) tick();
        flush = 1'b1;
        #1;
        chk("flc_hilo_we", 32'(hilo_we), 32'd1);
        chk("flc_done", 32'(done), 32'd1);
        tick();
        chk("flc_idle", 32'(busy), 32'd0);

        // Flush in IDLE beats a simultaneous issue
        issue(6'd25);
        flush = 1'b0;
        #1;
        chk("fli_busy", 32'(busy), 32'd0);

        // Asynchronous reset mid-RUN
        issue(6'd25);
        for (int i = 0; i < 6; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_outs", 32'({mul_load, mul_step, hilo_we, hilo_acc, done}), 32'd0);
        chk("arst_op", 32'(mul_op), 32'd0);
        chk("arst_cnt", 32'(step_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        issue(6'd25);
        run_full("post_rst", 6'b011001, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mdu_seq_ctl.md
# mdu_seq_ctl

Sequencer for the iterative 32-step multiply/divide-unit datapath in the pipelined MIPS-lite core. It accepts multu/maddu issues from EX and drives the external shift-add multiplier through load, step and commit phases. It owns the HI/LO write and accumulate controls, and raises a pipeline stall when a second multiply or an mfhi/mflo arrives while the unit is busy.

## Interface
- `STEPS`, default 32: number of RUN iterations; equals the operand width.
- `CNT_W`, default 6: iteration counter width; must satisfy 2^CNT_W > STEPS.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `issue_valid`  in  1: EX holds an R-type instruction this cycle.
- `issue_funct`  in  6: funct field; 25 = multu, 1 = maddu.
- `mf_req`  in  1: EX holds mfhi (funct 16) or mflo (funct 18).
- `flush`  in  1: squash the in-flight multiply (branch/exception).
- `stall`  out  1: freeze IF/ID/EX this cycle. Combinational.
- `busy`  out  1: state is not IDLE.
- `mul_load`  out  1: datapath latches operands and clears the partial product.
- `mul_step`  out  1: datapath performs one shift-add iteration.
- `mul_op`  out  6: 000000 idle; 011001 multu; 000001 maddu; 111111 commit.
- `hilo_we`  out  1: write the product into HI/LO at the next edge.
- `hilo_acc`  out  1: with `hilo_we`, add the product to {HI,LO} instead of overwriting.
- `done`  out  1: one-cycle pulse, coincident with `hilo_we`.
- `step_cnt`  out  CNT_W: current iteration index, for debug.

## Operation
- States are IDLE, LOAD, RUN and COMMIT. An instruction is a mul when `issue_funct` is 25, or 1 when maddu is enabled.
- **IDLE:** `issue_valid` with a mul and no `flush` is accepted.
  - The operation (mult or maddu) is latched.
  - The state goes to LOAD.
  - A non-mul `issue_valid` is ignored.
- **LOAD:**
  - `mul_load` = 1 and `step_cnt` = 0.
  - The state goes to RUN.
- **RUN:**
  - `mul_step` = 1.
  - `step_cnt` increments each cycle from 0 to STEPS-1.
  - When the count reaches STEPS-1, the state goes to COMMIT and `step_cnt` clears.
- **COMMIT:**
  - `hilo_we` = 1, `done` = 1 and `mul_op` = 111111.
  - `hilo_acc` = 1 when the latched operation is maddu.
  - The state goes to IDLE.
- `mul_op` shows the latched operation code during LOAD and RUN, and 000000 in IDLE.
- Stall rule: `stall` = `busy` & ((`issue_valid` & mul) | `mf_req`).
  - The stalled instruction remains in EX.
  - It is accepted, or its mfhi/mflo reads the updated HI/LO, in the first IDLE cycle.
- `stall` is never asserted in IDLE; a back-to-back mul issues with no bubble.
- **Flush:**
  - In LOAD or RUN, `flush` forces IDLE at the next edge. No `hilo_we` and no `done` are produced, and `step_cnt` clears.
  - In COMMIT, `flush` is ignored and the commit completes.
  - In IDLE, `flush` takes priority over a simultaneous issue, so the issue is not accepted.
- A stalled request that coincides with `flush` is dropped. `stall` is deasserted in that cycle.

## Timing
- On reset, every output is 0, the state is IDLE, `step_cnt` = 0 and the latched operation is cleared.
- Reset asserted mid-operation aborts immediately, and no HI/LO write occurs.
- Let E be the edge that accepts an issue.
  - LOAD occupies cycle E+1.
  - RUN occupies cycles E+2 through E+STEPS+1.
  - COMMIT occupies cycle E+STEPS+2.
  - IDLE resumes at E+STEPS+3.
- Total occupancy is STEPS+2 = 34 cycles. HI/LO is valid from edge E+STEPS+3.
- `stall` depends on the inputs within the same cycle. It has no registered delay.

## Configuration
- `MDU_MADDU_EN` defined:
  - Funct 1 is a mul, with `mul_op` = 000001 and `hilo_acc` = 1 at commit.
- `MDU_MADDU_EN` undefined:
  - Funct 1 is not a mul and is ignored, like any non-mul funct.
  - `hilo_acc` is tied to 0.
  - Only multu is sequenced.

## Test plan
- Reset, then issue funct 25. Expect:
  - `mul_load` high for exactly 1 cycle.
  - `mul_step` high for exactly 32 cycles.
  - At E+34, `hilo_we` = `done` = 1, `hilo_acc` = 0 and `mul_op` = 111111.
  - IDLE at E+35.
- Issue funct 1 with the macro defined: `mul_op` = 000001 and `hilo_acc` = 1 at commit. With the macro undefined, the same issue leaves `busy` = 0 and produces no `mul_load`.
- Assert `mf_req` during RUN at `step_cnt` = 10. Expect:
  - `stall` = 1 through COMMIT.
  - `stall` = 0 in the first IDLE cycle.
- Issue a second multu at RUN `step_cnt` = 5. Expect:
  - `stall` held until IDLE.
  - Acceptance on the first IDLE edge, then a new LOAD.
- Pulse `flush` at RUN `step_cnt` = 20: IDLE next cycle, no `hilo_we`, no `done`, `step_cnt` = 0. Pulse `flush` during COMMIT: `hilo_we` still asserted.
- Deassert `rst_n` asynchronously mid-RUN. Expect all outputs 0 without a clock edge. After release, a new issue runs the full 34 cycles.
